pipe_ctrl: RTL

Central stall/flush sequencer for the 5-stage core (IF, ID, EX, MA, WB).
- Merges the ID-stage data-hazard flag, I-cache/D-cache busy, EX branch-taken, multicycle mul/div handshake and MA trap into per-stage clock-enables, bubble-injects and PC-select strobes.
- Tracks long stalls in a small FSM with a watchdog and a stall-cycle counter.

---
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage enables, bubbles and PC-select strobes,
// plus a long-stall FSM with a sticky watchdog flag and a count of cycles in which IF is held.
module pipe_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_hz_data,
  input  logic             i_ic_busy,
  input  logic             i_dc_busy,
  input  logic             i_br_taken,
  input  logic             i_md_start,
  input  logic             i_md_done,
  input  logic             i_trap,
  output logic             o_ce_if,
  output logic             o_ce_id,
  output logic             o_ce_ex,
  output logic             o_ce_ma,
  output logic             o_ce_wb,
  output logic             o_fl_id,
  output logic             o_fl_ex,
  output logic             o_fl_ma,
  output logic             o_pc_br,
  output logic             o_pc_trap,
  output logic             o_md_abort,
  output logic [1:0]       o_state,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DWAIT = 2'd2,
    ST_MWAIT = 2'd3
  } state_t;

  // The watchdog saturates at its terminal value, so it only needs enough bits to reach TIMEOUT-1.
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             wait_q, wait_d;

  always_comb begin
    o_ce_if    = 1'b1;
    o_ce_id    = 1'b1;
    o_ce_ex    = 1'b1;
    o_ce_ma    = 1'b1;
    o_ce_wb    = 1'b1;
    o_fl_id    = 1'b0;
    o_fl_ex    = 1'b0;
    o_fl_ma    = 1'b0;
    o_pc_br    = 1'b0;
    o_pc_trap  = 1'b0;
    o_md_abort = 1'b0;
    state_d    = state_q;
    case (state_q)
      ST_INIT: begin
        {o_ce_if, o_ce_id, o_ce_ex, o_ce_ma, o_ce_wb} = 5'b00000;
        {o_fl_id, o_fl_ex, o_fl_ma} = 3'b111;
        state_d = ST_RUN;
      end
      // DWAIT behaves like RUN once the D-cache frees up, so both share one rule chain.
      ST_RUN, ST_DWAIT: begin
        if (i_dc_busy) begin
          {o_ce_if, o_ce_id, o_ce_ex, o_ce_ma, o_ce_wb} = 5'b00000;
          state_d = ST_DWAIT;
        end else if (i_trap) begin
          {o_fl_id, o_fl_ex, o_fl_ma} = 3'b111;
          o_pc_trap  = 1'b1;
          o_md_abort = i_md_start;
          state_d    = ST_RUN;
        end else if (i_md_start && !i_md_done) begin
          {o_ce_if, o_ce_id, o_ce_ex} = 3'b000;
          o_fl_ma = 1'b1;
          state_d = ST_MWAIT;
        end else begin
          state_d = ST_RUN;
          if (i_br_taken) begin
            o_fl_id = 1'b1;
            o_fl_ex = 1'b1;
            o_pc_br = 1'b1;
          end else if (i_hz_data) begin
            o_ce_if = 1'b0;
            o_ce_id = 1'b0;
            o_fl_ex = 1'b1;
          end else if (i_ic_busy) begin
            o_ce_if = 1'b0;
            o_fl_id = 1'b1;
          end
        end
      end
      ST_MWAIT: begin
        if (i_dc_busy) begin
          {o_ce_if, o_ce_id, o_ce_ex, o_ce_ma, o_ce_wb} = 5'b00000;
        end else if (i_trap) begin
          {o_fl_id, o_fl_ex, o_fl_ma} = 3'b111;
          o_pc_trap  = 1'b1;
          o_md_abort = 1'b1;
          state_d    = ST_RUN;
        end else if (i_md_done) begin
          o_fl_id = i_br_taken;
          o_fl_ex = i_br_taken;
          o_pc_br = i_br_taken;
          state_d = ST_RUN;
        end else begin
          {o_ce_if, o_ce_id, o_ce_ex} = 3'b000;
          o_fl_ma = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    wait_q    = (state_q == ST_DWAIT) || (state_q == ST_MWAIT);
    wait_d    = (state_d == ST_DWAIT) || (state_d == ST_MWAIT);
    wd_d      = '0;
    if (wait_q) wd_d = (wd_q == WD_LAST) ? wd_q : wd_q + 1'b1;
    timeout_d = timeout_q | ((TIMEOUT != 0) && wait_q && wait_d && (wd_q == WD_LAST));
    stall_d   = stall_q;
    if ((state_q != ST_INIT) && !o_ce_if) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_INIT;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
    end
  end

  assign o_state     = state_q;
  assign o_timeout   = timeout_q;
  assign o_stall_cnt = stall_q;

endmodule
